// File: rtl/spi_regfile_peripheral_if.sv
// SPI Mode-0 pin bundle between an external controller and the register-file peripheral.
interface spi_regfile_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, copi, ncs, input cipo, cipo_oe);
  modport slave  (input sclk, copi, ncs, output cipo, cipo_oe);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI Mode-0 peripheral exposing a NUM_REGS x DATA_W register file with read-back
// and malformed-frame counting; all SPI pins are oversampled in the clk domain.
module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_peripheral_if.slave    spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 frame_err_cnt
);
  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam int TXC_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FRAME     = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0]  CNT_SAT       = CNT_W'(FRAME + 1);
  localparam logic [CNT_W-1:0]  CNT_ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [TXC_W-1:0]  TXC_DONE      = TXC_W'(DATA_W);
  localparam logic [ADDR_W:0]   ADDR_LIMIT    = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_COMMIT
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic sclk_d, ncs_d;
  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  state_t state_q, state_d;
  logic   frame_start, frame_end, sampling, commit;

  logic [CNT_W-1:0]  bit_cnt;
  logic [FRAME-1:0]  rx_sh, rx_next;
  logic [DATA_W-1:0] tx_sh;
  logic [TXC_W-1:0]  tx_cnt;
  logic              cipo_q, cipo_oe_q;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic              frame_ok, cm_wr, cm_in_range;
  logic [ADDR_W-1:0] cm_addr;
  logic [DATA_W-1:0] cm_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A rising ncs only commits if a falling edge opened the frame, so the
  // synchroniser settling after reset (or a frame cut by reset) is never counted.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    sampling    = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d     = ST_FRAME;
          frame_start = 1'b1;
        end
      end
      ST_FRAME: begin
        if (ncs_rise) begin
          state_d   = ST_COMMIT;
          frame_end = 1'b1;
        end else begin
          sampling = 1'b1;
        end
      end
      ST_COMMIT: begin
        commit = 1'b1;
        if (ncs_fall) begin
          state_d     = ST_FRAME;
          frame_start = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_next = {rx_sh[FRAME-2:0], copi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      rx_sh   <= '0;
    end else if (frame_start) begin
      bit_cnt <= '0;
      rx_sh   <= '0;
    end else if (sampling && sclk_rise) begin
      rx_sh <= rx_next;
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign rd_addr = rx_next[ADDR_W-1:0];

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ({1'b0, rd_addr} == (ADDR_W+1)'(i)) rd_data = regs[i];
    end
  end

  // TX loads on the rising edge that completes the address, then advances on falling edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh     <= '0;
      tx_cnt    <= '0;
      cipo_q    <= 1'b0;
      cipo_oe_q <= 1'b0;
    end else if (frame_end || frame_start) begin
      tx_cnt    <= '0;
      cipo_q    <= 1'b0;
      cipo_oe_q <= 1'b0;
    end else if (sampling && sclk_rise && bit_cnt == CNT_ADDR_LAST && !rx_next[ADDR_W]) begin
      tx_sh     <= rd_data;
      tx_cnt    <= '0;
      cipo_oe_q <= 1'b1;
    end else if (sampling && sclk_fall && cipo_oe_q && tx_cnt != TXC_DONE) begin
      cipo_q <= tx_sh[DATA_W-1];
      tx_sh  <= tx_sh << 1;
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = cipo_oe_q;

  assign frame_ok    = (bit_cnt == CNT_FRAME);
  assign cm_wr       = rx_sh[FRAME-1];
  assign cm_addr     = rx_sh[DATA_W +: ADDR_W];
  assign cm_data     = rx_sh[DATA_W-1:0];
  assign cm_in_range = ({1'b0, cm_addr} < ADDR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse      <= 1'b0;
      wr_addr       <= '0;
      frame_err_cnt <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (commit) begin
        if (!frame_ok) begin
          if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
        end else if (cm_wr && cm_in_range) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if ({1'b0, cm_addr} == (ADDR_W+1)'(i)) regs[i] <= cm_data;
          end
          wr_addr  <= cm_addr;
          wr_pulse <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule
